ifm_window_streamer: RTL and testbench



---
 rtl/ifm_window_streamer.sv | 117 +++++++++++
 tb/tb_ifm_window_streamer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ifm_window_streamer.sv
// Streams one IFM channel from RAM into the KERNAL_SIZE line-buffer window FIFO and flags complete windows.
// Latency: first read the cycle after start, push one cycle after each read, window_valid one cycle after push.
// Backpressure: stall freezes reads, pushes, counters and FSM; an in-flight return is parked in a one-entry holding register.
module ifm_window_streamer #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 32,
    parameter int KERNAL_SIZE           = 2,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stall,
    input  logic [DATA_WIDTH-1:0]            ram_data_in,
    output logic                             ram_rd_en,
    output logic [ADDRESS_SIZE_IFM-1:0]      ram_rd_addr,
    output logic                             fifo_enable,
    output logic [DATA_WIDTH-1:0]            fifo_data_out,
    output logic                             window_valid,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr,
    output logic                             busy,
    output logic                             done
);
    localparam int NPIX  = IFM_SIZE * IFM_SIZE;
    localparam int CNT_W = ADDRESS_SIZE_IFM + 1;
    localparam int RC_W  = $clog2(IFM_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                           state, state_n;
    logic [CNT_W-1:0]                 rd_cnt;
    logic [CNT_W-1:0]                 push_cnt;
    logic [RC_W-1:0]                  row;
    logic [RC_W-1:0]                  col;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] win_cnt;
    logic                             rd_pend;
    logic                             hold_full;
    logic [DATA_WIDTH-1:0]            hold_dat;
    logic                             read_go;
    logic                             push;
    logic                             win_hit;

    // Holding register drains before any fresh return; both cannot coincide since stall also blocks reads.
    always_comb begin
        read_go       = (state == RUN) && !stall;
        push          = !stall && (hold_full || rd_pend);
        win_hit       = (row >= RC_W'(KERNAL_SIZE - 1)) && (col >= RC_W'(KERNAL_SIZE - 1));
        ram_rd_en     = read_go;
        ram_rd_addr   = read_go ? rd_cnt[ADDRESS_SIZE_IFM-1:0] : '0;
        fifo_enable   = push;
        fifo_data_out = push ? (hold_full ? hold_dat : ram_data_in) : '0;
        busy          = (state != IDLE);
        done          = (state == DONE);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (read_go && rd_cnt == CNT_W'(NPIX - 1)) state_n = FLUSH;
            FLUSH:   if (!stall && push_cnt == CNT_W'(NPIX)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            push_cnt     <= '0;
            row          <= '0;
            col          <= '0;
            win_cnt      <= '0;
            rd_pend      <= 1'b0;
            hold_full    <= 1'b0;
            hold_dat     <= '0;
            window_valid <= 1'b0;
            ofm_addr     <= '0;
        end else begin
            state        <= state_n;
            rd_pend      <= read_go;
            window_valid <= push && win_hit;
            if (state == IDLE && start) begin
                rd_cnt   <= '0;
                push_cnt <= '0;
                row      <= '0;
                col      <= '0;
                win_cnt  <= '0;
                ofm_addr <= '0;
            end
            if (read_go)
                rd_cnt <= rd_cnt + 1'b1;
            if (rd_pend && stall) begin
                hold_full <= 1'b1;
                hold_dat  <= ram_data_in;
            end else if (push) begin
                hold_full <= 1'b0;
            end
            if (push) begin
                push_cnt <= push_cnt + 1'b1;
                if (col == RC_W'(IFM_SIZE - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (win_hit) begin
                    ofm_addr <= win_cnt;
                    win_cnt  <= win_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ifm_window_streamer.sv
// Directed bench: cycle-exact trace checks on a 4x4 instance, window scoreboard on a 32x32 instance.
module tb_ifm_window_streamer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic        start4 = 1'b0, stall4 = 1'b0;
    logic [31:0] ram4;
    logic        rd_en4, fe4, wv4, busy4, done4;
    logic [3:0]  rd_addr4;
    logic [31:0] fd4;
    logic [3:0]  ofm4;
    // 32x32 instance
    logic        start32 = 1'b0, stall32 = 1'b0;
    logic [31:0] ram32;
    logic        rd_en32, fe32, wv32, busy32, done32;
    logic [9:0]  rd_addr32;
    logic [31:0] fd32;
    logic [9:0]  ofm32;

    logic [31:0] mem4 [16];
    logic [31:0] mem32 [1024];

    int checks = 0;
    int errors = 0;

    ifm_window_streamer #(.DATA_WIDTH(32), .IFM_SIZE(4), .KERNAL_SIZE(2)) dut (
        .clk(clk), .reset(reset), .start(start4), .stall(stall4), .ram_data_in(ram4),
        .ram_rd_en(rd_en4), .ram_rd_addr(rd_addr4), .fifo_enable(fe4), .fifo_data_out(fd4),
        .window_valid(wv4), .ofm_addr(ofm4), .busy(busy4), .done(done4));

    ifm_window_streamer #(.DATA_WIDTH(32), .IFM_SIZE(32), .KERNAL_SIZE(2)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .stall(stall32), .ram_data_in(ram32),
        .ram_rd_en(rd_en32), .ram_rd_addr(rd_addr32), .fifo_enable(fe32), .fifo_data_out(fd32),
        .window_valid(wv32), .ofm_addr(ofm32), .busy(busy32), .done(done32));

    always @(posedge clk) begin
        ram4  <= mem4[rd_addr4];
        ram32 <= mem32[rd_addr32];
    end

    typedef struct packed {
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic        fe;
        logic [31:0] fd;
        logic        wv;
        logic        done;
        logic        busy;
    } obs_t;

    typedef struct {
        int cyc;
        int ofm;
    } vrec_t;

    vrec_t vtab [9];

    function automatic obs_t sample4();
        obs_t o;
        o.rd_en = rd_en4; o.rd_addr = rd_addr4; o.fe = fe4; o.fd = fd4;
        o.wv = wv4; o.done = done4; o.busy = busy4;
        return o;
    endfunction

    // Unstalled reference trace of one 4x4 stream, cycle 0 = cycle start is driven.
    function automatic obs_t nominal(int n);
        obs_t o = '0;
        if (n >= 1 && n <= 16) begin o.rd_en = 1'b1; o.rd_addr = 4'(n - 1); end
        if (n >= 2 && n <= 17) begin o.fe = 1'b1; o.fd = 32'(n - 2); end
        for (int i = 0; i < 9; i++) if (vtab[i].cyc == n) o.wv = 1'b1;
        o.done = (n == 19);
        o.busy = (n >= 1 && n <= 19);
        return o;
    endfunction

    function automatic int nominal_ofm(int n);
        int v = 0;
        for (int i = 0; i < 9; i++) if (vtab[i].cyc <= n) v = vtab[i].ofm;
        return v;
    endfunction

    task automatic chk_obs(input string name, input int c, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, c, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0d want %0d", name, c, act, exp);
        end
    endtask

    // Drive one 4x4 stream for ncyc cycles; optional stall window and extra start pulses.
    task automatic run4(input string name, input int ncyc, input int lo, input int hi,
                        input int rs1, input int rs2);
        int   len;
        obs_t e;
        int   eofm;
        len = (hi >= lo) ? hi - lo + 1 : 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start4 = (c == 0) || (c == rs1) || (c == rs2);
            stall4 = (len > 0) && (c >= lo) && (c <= hi);
            @(negedge clk);
            if (len > 0 && c >= lo && c <= hi) begin
                e = '0;
                e.busy = 1'b1;
                e.wv = (c == lo) ? nominal(lo).wv : 1'b0;
                eofm = nominal_ofm(lo);
            end else begin
                e = nominal((len > 0 && c > hi) ? c - len : c);
                eofm = nominal_ofm((len > 0 && c > hi) ? c - len : c);
            end
            chk_obs(name, c, sample4(), e);
            if (c >= 1) chk_int({name, "_ofm"}, c, int'(ofm4), eofm);
        end
        start4 = 1'b0;
        stall4 = 1'b0;
    endtask

    task automatic run32();
        int     reads = 0, pushes = 0, valids = 0, tl, r, c;
        bit     seen_done = 1'b0;
        logic [31:0] pushed [1024];
        @(posedge clk); #1;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (wv32) begin
                r  = int'(ofm32) / 31;
                c  = int'(ofm32) % 31;
                tl = pushes - 1 - 33;
                chk_int("win_pos", cyc, tl, r * 32 + c);
                if (tl >= 0 && tl < 1024) begin
                    chk_int("win_col", cyc, (tl % 32 == 31) ? 1 : 0, 0);
                    chk_int("win_tl", cyc, int'(pushed[tl]), int'(mem32[r * 32 + c]));
                end
                valids++;
            end
            if (fe32) begin
                if (pushes < 1024) pushed[pushes] = fd32;
                pushes++;
            end
            if (rd_en32) reads++;
            if (done32) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        chk_int("s32_done", 0, seen_done ? 1 : 0, 1);
        chk_int("s32_reads", 0, reads, 1024);
        chk_int("s32_pushes", 0, pushes, 1024);
        chk_int("s32_valids", 0, valids, 961);
        chk_int("s32_last_ofm", 0, int'(ofm32), 960);
        @(negedge clk);
        chk_int("s32_busy_after", 0, int'(busy32), 0);
    endtask

    initial begin
        vtab[0] = '{8, 0};  vtab[1] = '{9, 1};  vtab[2] = '{10, 2};
        vtab[3] = '{12, 3}; vtab[4] = '{13, 4}; vtab[5] = '{14, 5};
        vtab[6] = '{16, 6}; vtab[7] = '{17, 7}; vtab[8] = '{18, 8};
        for (int i = 0; i < 16; i++) mem4[i] = 32'(i);
        for (int i = 0; i < 1024; i++) mem32[i] = $urandom;

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_obs("reset4", 0, sample4(), '0);
        chk_int("reset4_ofm", 0, int'(ofm4), 0);
        chk_int("reset32", 0, int'({rd_en32, rd_addr32, fe32, fd32, wv32, ofm32, busy32, done32}), 0);

        run4("plain", 25, -1, -2, -1, -1);
        run4("stall", 28, 5, 7, -1, -1);

        // Mid-stream reset: outputs clear immediately and no done pulse follows.
        run4("pre_rst", 9, -1, -2, -1, -1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 10; c < 30; c++) begin
            @(negedge clk);
            chk_obs("after_rst", c, sample4(), '0);
            chk_int("after_rst_ofm", c, int'(ofm4), 0);
            @(posedge clk); #1;
        end
        run4("restream", 25, -1, -2, -1, -1);

        run4("restart_ign", 25, -1, -2, 3, 10);

        run4("b2b_first", 20, -1, -2, -1, -1);
        run4("b2b_second", 25, -1, -2, -1, -1);

        run32();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
